// File: rtl/b1_pkg.sv
// Shared types and the per-lane b1 function for the lane-parallel b1 pipeline.
package b1_pkg;

  localparam int unsigned RES_PER_LANE = 4;

  typedef struct packed {
    logic d;
    logic e;
    logic f;
    logic g;
  } b1_res_t;

  function automatic b1_res_t b1_eval(input logic a, input logic b, input logic c);
    b1_res_t r;
    r.d = c;
    r.e = a ^ b;
    r.f = (~a & ~b & c) | (a & b & ~c);
    r.g = ~c;
    return r;
  endfunction

endpackage

// File: rtl/b1_lanes_pipe_if.sv
// Handshake, operand and result bundle between the b1 pipeline and its neighbours.
interface b1_lanes_pipe_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 8
);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] pa;
  logic [LANES-1:0] pb;
  logic [LANES-1:0] pc;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] pd;
  logic [LANES-1:0] pe;
  logic [LANES-1:0] pf;
  logic [LANES-1:0] pg;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output flush, in_valid, pa, pb, pc, out_ready,
    input  in_ready, out_valid, pd, pe, pf, pg, beat_cnt
  );

  modport slave (
    input  flush, in_valid, pa, pb, pc, out_ready,
    output in_ready, out_valid, pd, pe, pf, pg, beat_cnt
  );

endinterface

// File: rtl/b1_pipe_stage.sv
// One elastic register stage: a valid bit plus payload, loaded on load_i, valid cleared by clr_i.
module b1_pipe_stage #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             v_q, v_d;
  logic [Width-1:0] data_q, data_d;

  // Clear only drops the valid bit; the payload is left untouched.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (clr_i) begin
      v_d = 1'b0;
    end else if (load_i) begin
      v_d    = valid_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = data_q;

endmodule

// File: rtl/b1_lanes_pipe.sv
// Lane-parallel b1 function feeding a DEPTH-stage elastic pipeline, plus an accepted-beat counter.
module b1_lanes_pipe
  import b1_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  b1_lanes_pipe_if.slave bus
);

  localparam int unsigned RES_W = RES_PER_LANE * LANES;

  logic [LANES-1:0] res_d, res_e, res_f, res_g;
  logic [RES_W-1:0] eval_res;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    b1_res_t r;
    assign r        = b1_eval(bus.pa[i], bus.pb[i], bus.pc[i]);
    assign res_d[i] = r.d;
    assign res_e[i] = r.e;
    assign res_f[i] = r.f;
    assign res_g[i] = r.g;
  end

  assign eval_res = {res_d, res_e, res_f, res_g};

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic             accept;

  // A stage may advance if it is empty or its downstream neighbour advances.
  always_comb begin
    adv          = '0;
    adv[DEPTH-1] = ~v[DEPTH-1] | bus.out_ready;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k] = ~v[k] | adv[k+1];
    end
  end

  assign bus.in_ready = adv[0] & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  logic [RES_W-1:0] stage_q [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic [RES_W-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_v    = accept;
      assign up_data = eval_res;
    end else begin : g_body
      assign up_v    = v[k-1];
      assign up_data = stage_q[k-1];
    end

    b1_pipe_stage #(
      .Width (RES_W)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .clr_i   (bus.flush),
      .load_i  (adv[k]),
      .valid_i (up_v),
      .data_i  (up_data),
      .valid_o (v[k]),
      .data_o  (stage_q[k])
    );
  end

  assign bus.out_valid                      = v[DEPTH-1];
  assign {bus.pd, bus.pe, bus.pf, bus.pg}   = stage_q[DEPTH-1];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.beat_cnt = cnt_q;

endmodule

// File: tb/tb_b1_lanes_pipe.sv
// Randomised scoreboard bench for b1_lanes_pipe with directed latency, stall, flush and reset cases.
module tb_b1_lanes_pipe;

  localparam int unsigned L  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 4 * L;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  b1_lanes_pipe_if #(.LANES(L), .CNT_W(CW)) bus ();

  b1_lanes_pipe #(
    .LANES (L),
    .DEPTH (D),
    .CNT_W (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int              n_cmp = 0;
  int              n_err = 0;
  logic [RW-1:0]   exp_q[$];
  logic [CW-1:0]   cnt_m = '0;
  int              rst_epoch = 0;

  // Reference: d=c, e=a^b, f only for (0,0,1)/(1,1,0), g=~c.
  function automatic logic [RW-1:0] ref_b1(input logic [L-1:0] a, b, c);
    logic [L-1:0] f;
    for (int i = 0; i < L; i++) begin
      f[i] = ({a[i], b[i], c[i]} == 3'b001) || ({a[i], b[i], c[i]} == 3'b110);
    end
    return {c, a ^ b, f, ~c};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [L-1:0] a, b, c,
                       input logic ordy, input logic fl);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.pa        = a;
    bus.pb        = b;
    bus.pc        = c;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #2;
    if (rst_n) cmp("beat_cnt", bus.beat_cnt, cnt_m);
    if (rst_n && iv && bus.in_ready) begin
      exp_q.push_back(ref_b1(a, b, c));
      cnt_m++;
    end
    #1;
    if (fl && rst_n) exp_q.delete();
  endtask

  task automatic rnd_cycle(input logic iv, input logic ordy, input logic fl);
    logic [31:0] r;
    r = $urandom();
    cycle(iv, r[L-1:0], r[2*L-1:L], r[3*L-1:2*L], ordy, fl);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  logic [RW-1:0] mon_cur, mon_prev;
  logic          mon_stall = 1'b0;
  logic          mon_fl = 1'b0;
  int            mon_epoch = 0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        mon_cur = {bus.pd, bus.pe, bus.pf, bus.pg};
        if (mon_stall && mon_epoch == rst_epoch && !mon_fl) begin
          cmp("hold_valid", bus.out_valid, 1);
          if (bus.out_valid) cmp("hold_data", mon_cur, mon_prev);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_data: got %0h expected no beat", mon_cur);
          end else begin
            cmp("out_data", mon_cur, exp_q.pop_front());
          end
        end
        mon_stall = bus.out_valid && !bus.out_ready;
        mon_prev  = mon_cur;
        mon_fl    = bus.flush;
        mon_epoch = rst_epoch;
      end else begin
        mon_stall = 1'b0;
      end
    end
  end

  initial begin
    logic [CW-1:0] cnt_before;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    bus.pa        = '0;
    bus.pb        = '0;
    bus.pc        = '0;

    #12;
    cmp("rst_out_valid", bus.out_valid, 0);
    cmp("rst_outs", {bus.pd, bus.pe, bus.pf, bus.pg}, 0);
    cmp("rst_beat_cnt", bus.beat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    cmp("rst_in_ready", bus.in_ready, 1);

    // Truth table across all eight (a,b,c) combinations.
    cycle(1'b1, 8'hF0, 8'hCC, 8'hAA, 1'b1, 1'b0);
    for (int k = 1; k <= int'(D) + 1; k++) begin
      cycle(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      cmp("tt_valid", bus.out_valid, k == int'(D));
      if (k == int'(D)) begin
        cmp("tt_pd", bus.pd, 8'hAA);
        cmp("tt_pe", bus.pe, 8'h3C);
        cmp("tt_pf", bus.pf, 8'h42);
        cmp("tt_pg", bus.pg, 8'h55);
      end
    end

    // Streaming: 10 back-to-back beats.
    for (int i = 0; i <= 10 + int'(D); i++) begin
      rnd_cycle(i < 10, 1'b1, 1'b0);
      if (i < 10) cmp("stream_in_ready", bus.in_ready, 1);
      cmp("stream_valid", bus.out_valid, (i >= int'(D)) && (i < 10 + int'(D)));
    end

    // Backpressure: only DEPTH beats fit while the output is stalled.
    for (int i = 0; i < int'(D) + 4; i++) begin
      rnd_cycle(1'b1, 1'b0, 1'b0);
      cmp("bp_in_ready", bus.in_ready, i < int'(D));
    end
    for (int i = 0; i < int'(D) + 3; i++) rnd_cycle(1'b0, 1'b1, 1'b0);
    cmp("bp_drained", exp_q.size(), 0);

    // Flush with two beats in flight and input still offered.
    rnd_cycle(1'b1, 1'b0, 1'b0);
    rnd_cycle(1'b1, 1'b0, 1'b0);
    cnt_before = cnt_m;
    rnd_cycle(1'b1, 1'b0, 1'b1);
    cmp("flush_in_ready", bus.in_ready, 0);
    rnd_cycle(1'b0, 1'b1, 1'b0);
    cmp("flush_out_valid", bus.out_valid, 0);
    cmp("flush_cnt", bus.beat_cnt, cnt_before);

    // Asynchronous reset between edges while streaming.
    for (int i = 0; i < 3; i++) rnd_cycle(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #4;
    rst_n = 1'b0;
    rst_epoch++;
    #1;
    cmp("amid_out_valid", bus.out_valid, 0);
    cmp("amid_outs", {bus.pd, bus.pe, bus.pf, bus.pg}, 0);
    cmp("amid_beat_cnt", bus.beat_cnt, 0);
    exp_q.delete();
    cnt_m = '0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    cmp("arel_in_ready", bus.in_ready, 1);
    rnd_cycle(1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= int'(D) + 1; k++) begin
      rnd_cycle(1'b0, 1'b1, 1'b0);
      cmp("arel_latency", bus.out_valid, k == int'(D));
    end

    // Counter wrap: 17 accepts since reset on a 4-bit counter.
    for (int i = 0; i < 16; i++) rnd_cycle(1'b1, 1'b1, 1'b0);
    rnd_cycle(1'b0, 1'b1, 1'b0);
    cmp("wrap_cnt", bus.beat_cnt, 1);

    // Random traffic with stalls and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rnd_cycle(($urandom() % 4) != 0, ($urandom() % 3) != 0, ($urandom() % 40) == 0);
    end

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) rnd_cycle(1'b0, 1'b1, 1'b0);
    cmp("final_drain", exp_q.size(), 0);
    rnd_cycle(1'b0, 1'b1, 1'b0);
    cmp("final_idle", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/b1_lanes_pipe.md
Name: b1_lanes_pipe

Overview:
- Parametrised, pipelined successor to the 3-in/4-out b1 logic benchmark.
- Evaluates the b1 function bitwise on LANES independent lanes and pushes the results through DEPTH elastic register stages with a valid/ready handshake.
- Also keeps a wrap-around count of accepted beats.
- Used as a sequential benchmark and as a golden source for clocked FCN layouts of the b1 function.

Parameters:
- LANES, 4, number of independent bit lanes; each input and output bus is LANES bits wide (min 1).
- DEPTH, 2, number of pipeline register stages between input and output (min 1).
- CNT_W, 8, width of the accepted-beat counter.

Ports:
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all stage valid bits.
- in_valid  in  1  input beat is present.
- in_ready  out  1  block accepts the beat this cycle.
- pa  in  LANES  operand a, one bit per lane.
- pb  in  LANES  operand b.
- pc  in  LANES  operand c.
- out_valid  out  1  output beat is present.
- out_ready  in  1  downstream accepts the output beat.
- pd  out  LANES  per-lane c.
- pe  out  LANES  per-lane a XOR b.
- pf  out  LANES  per-lane (~a&~b&c) | (a&b&~c).
- pg  out  LANES  per-lane ~c.
- beat_cnt  out  CNT_W  number of accepted input beats, modulo 2^CNT_W.

Behaviour:
- Function, evaluated combinationally at the input per lane:
  - d=c, e=a^b, g=~c.
  - f=1 only for (a,b,c)=(0,0,1) or (1,1,0).
  - Lanes never interact.
- Only the 4 result buses move through the pipeline; raw inputs are not stored.
- Stages: s0..s(DEPTH-1). Each stage holds v[k] plus 4*LANES data bits. The last stage drives out_valid and pd..pg directly, so outputs are registered.
- Advance rule:
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - adv[k] = ~v[k] | adv[k+1].
  - This gives full throughput with no bubble: a full pipeline moves every cycle when out_ready=1.
- in_ready = adv[0] & ~flush. This is combinational from out_ready through the valid chain and is a documented path.
- Accept = in_valid & in_ready. On accept, s0 loads the evaluated function and v[0]<=1.
- When adv[k] is set, stage k loads from stage k-1, or from the input for k=0. Its v[k] takes the upstream valid, or the accept signal for k=0.
- Latency: DEPTH cycles from accept to out_valid when never stalled.
- Holding: while out_valid=1 and out_ready=0, pd..pg and out_valid stay stable; upstream stages fill up, then in_ready drops.
- flush=1:
  - All v[k]<=0 at the next edge. Data regs are don't-care but are held.
  - No accept that cycle (in_ready=0).
  - beat_cnt is not incremented and is not cleared.
- beat_cnt increments by 1 per accept and wraps from 2^CNT_W-1 to 0.
- Reset (rst_n=0, asynchronous):
  - All v=0, so out_valid=0 and in_ready=1 once released.
  - pd, pe, pf, pg = 0; beat_cnt = 0.
  - Reset mid-stream discards all in-flight beats.
- Protocol:
  - A stalled output beat is never dropped or altered.
  - Input data is sampled only on accept; changing pa/pb/pc while in_ready=0 has no effect.
- DEPTH=1: the single stage is both s0 and the output stage; the same rules apply.

Decomposition:
- Package b1_pkg:
  - struct b1_res_t holding d, e, f, g for a parametric lane count (or a function taking and returning LANES-wide vectors).
  - function b1_eval(a,b,c).
  - localparam RES_W = 4*LANES.
- Sub-module b1_pipe_stage: one elastic stage with v, data, load enable and synchronous clear. Instantiated DEPTH times in a generate loop.
- Top level holds only b1_eval, the adv chain and beat_cnt.

Test Plan:
- Exhaustive truth table, LANES=8, DEPTH=2, out_ready=1: pa=8'hF0, pb=8'hCC, pc=8'hAA -> after 2 cycles pd=AA, pe=3C, pf=42, pg=55, out_valid=1 for exactly 1 cycle.
- Streaming: 10 back-to-back beats with out_ready=1 -> in_ready stays 1, outputs appear in order on 10 consecutive cycles, beat_cnt=10.
- Backpressure: out_ready=0 after the first beat, keep driving in_valid -> DEPTH beats accepted, then in_ready=0. pd..pg hold stable. On release, all beats exit in order with no loss or duplication.
- Flush: flush=1 with 2 beats in flight and in_valid=1 -> next cycle out_valid=0, no accept that cycle, beat_cnt unchanged.
- Wrap: CNT_W=4, 17 accepts -> beat_cnt=1.
- Async reset mid-stream: assert rst_n=0 between clock edges -> out_valid=0, outputs and beat_cnt=0 immediately. After release, in_ready=1 and the first new beat emerges after DEPTH cycles.
